// File: rtl/seq_array_multiplier.sv
// Iterative shift-add multiplier, one partial-product row per clock.
// Signed mode works on magnitudes and negates the final product.
module seq_array_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] m,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nx;
  logic [PW-1:0]    addend;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             last;

  assign last     = (cnt == CW'(WIDTH - 1));
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // -2^(W-1) negates to itself, which reads correctly as unsigned
  always_comb begin
    a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
    addend = '0;
    if (mplier[0])
      addend = {{WIDTH{1'b0}}, mcand} << cnt;
    acc_nx = acc + addend;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      m         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_nx;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            m         <= neg ? -acc_nx : acc_nx;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed and randomised checks of seq_array_multiplier at WIDTH 4 and 8.
// All sampling and driving happens on the falling clock edge.
module tb_seq_array_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv4 = 0, ir4, s4 = 0, ov4, or4 = 0, bz4;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] m4;

  logic        iv8 = 0, ir8, s8 = 0, ov8, or8 = 0, bz8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] m8;

  int total = 0;
  int bad = 0;

  seq_array_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .sgn(s4),
    .out_valid(ov4), .out_ready(or4),
    .m(m4), .busy(bz4)
  );

  seq_array_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .sgn(s8),
    .out_valid(ov8), .out_ready(or8),
    .m(m8), .busy(bz8)
  );

  // Launch one WIDTH=4 op, return latency and product, then accept it.
  task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                        input logic s, output int lat,
                        output logic [7:0] prod);
    iv4 = 1; a4 = a; b4 = b; s4 = s;
    @(negedge clk);
    iv4 = 0;
    lat = 1;
    while (!ov4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    prod = m4;
    or4 = 1;
    @(negedge clk);
    or4 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    total++;
    if (ir4 !== 1 || ov4 !== 0 || bz4 !== 0 || m4 !== 8'h00) begin
      bad++;
      $display("FAIL reset: ir=%b ov=%b busy=%b m=%h want 1 0 0 00",
               ir4, ov4, bz4, m4);
    end
    rst = 0;
    @(negedge clk);
    total++;
    if (ir4 !== 1 || ir8 !== 1) begin
      bad++;
      $display("FAIL reset_release: ir4=%b ir8=%b want 1", ir4, ir8);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    logic [7:0] p;
    do_op4(4'hF, 4'hF, 0, lat, p);
    total++;
    if (p !== 8'hE1 || lat !== 5) begin
      bad++;
      $display("FAIL u_15x15: m=%h lat=%0d want e1 5", p, lat);
    end
    total++;
    if (ir4 !== 1 || ov4 !== 0) begin
      bad++;
      $display("FAIL u_after_ack: ir=%b ov=%b want 1 0", ir4, ov4);
    end
    do_op4(4'h0, 4'h9, 0, lat, p);
    total++;
    if (p !== 8'h00 || lat !== 5) begin
      bad++;
      $display("FAIL u_0x9: m=%h lat=%0d want 00 5", p, lat);
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [7:0] p;
    do_op4(4'h8, 4'h8, 1, lat, p);
    total++;
    if (p !== 8'h40 || lat !== 5) begin
      bad++;
      $display("FAIL s_m8xm8: m=%h lat=%0d want 40 5", p, lat);
    end
    do_op4(4'hD, 4'h5, 1, lat, p);
    total++;
    if (p !== 8'hF1 || lat !== 5) begin
      bad++;
      $display("FAIL s_m3x5: m=%h lat=%0d want f1 5", p, lat);
    end
    do_op4(4'h7, 4'hF, 1, lat, p);
    total++;
    if (p !== 8'hF9 || lat !== 5) begin
      bad++;
      $display("FAIL s_7xm1: m=%h lat=%0d want f9 5", p, lat);
    end
  endtask

  task automatic test_backpressure();
    int n;
    iv4 = 1; a4 = 4'h2; b4 = 4'h3; s4 = 0;
    @(negedge clk);
    iv4 = 1; a4 = 4'h5; b4 = 4'h5;
    @(negedge clk);
    total++;
    if (ir4 !== 0 || bz4 !== 1) begin
      bad++;
      $display("FAIL bp_run: ir=%b busy=%b want 0 1", ir4, bz4);
    end
    iv4 = 0;
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      iv4 = i[0];
      a4 = 4'h5; b4 = 4'h5;
      total++;
      if (ov4 !== 1 || m4 !== 8'h06 || ir4 !== 0) begin
        bad++;
        $display("FAIL bp_hold%0d: ov=%b m=%h ir=%b want 1 06 0",
                 i, ov4, m4, ir4);
      end
      @(negedge clk);
    end
    iv4 = 0;
    or4 = 1;
    @(negedge clk);
    or4 = 0;
    total++;
    if (ir4 !== 1 || ov4 !== 0 || bz4 !== 0 || m4 !== 8'h06) begin
      bad++;
      $display("FAIL bp_release: ir=%b ov=%b busy=%b m=%h want 1 0 0 06",
               ir4, ov4, bz4, m4);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [7:0] p;
    logic seen;
    iv4 = 1; a4 = 4'h9; b4 = 4'h7; s4 = 0;
    @(negedge clk);
    iv4 = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    total++;
    if (ir4 !== 1 || bz4 !== 0 || ov4 !== 0 || m4 !== 8'h00) begin
      bad++;
      $display("FAIL rst_run: ir=%b busy=%b ov=%b m=%h want 1 0 0 00",
               ir4, bz4, ov4, m4);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov4) seen = 1;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_no_ov: saw=%b want 0", seen);
    end
    do_op4(4'h3, 4'h5, 0, lat, p);
    total++;
    if (p !== 8'h0F || lat !== 5) begin
      bad++;
      $display("FAIL rst_then_3x5: m=%h lat=%0d want 0f 5", p, lat);
    end
  endtask

  task automatic test_random_w8();
    int in_hs, out_hs, lat, errs;
    logic [15:0] exp;
    in_hs = 0; out_hs = 0; errs = 0;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      s8 = 1'($urandom);
      if (s8) exp = 16'($signed(a8) * $signed(b8));
      else    exp = 16'(a8) * 16'(b8);
      or8 = 1'($urandom);
      iv8 = 1;
      if (ir8) in_hs++;
      @(negedge clk);
      iv8 = 0;
      lat = 1;
      while (!ov8 && lat < 30) begin
        or8 = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      or8 = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      total++;
      if (m8 !== exp || lat !== 9) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd%0d: a=%h b=%h s=%b m=%h lat=%0d want %h 9",
                   i, a8, b8, s8, m8, lat, exp);
      end
      or8 = 1;
      if (ov8) out_hs++;
      @(negedge clk);
      or8 = 0;
    end
    total++;
    if (in_hs !== 1000 || out_hs !== 1000) begin
      bad++;
      $display("FAIL rnd_hs: in=%0d out=%0d want 1000 1000", in_hs, out_hs);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid_run();
    test_random_w8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_array_multiplier.md
# seq_array_multiplier

Parametrised, iterative shift-add multiplier that succeeds the combinational 4-bit array multiplier in the arithmetic library. It takes WIDTH-bit operands through a valid/ready handshake and computes one partial-product row per clock instead of instantiating a full adder array. It supports per-operation signed (two's-complement) or unsigned mode and holds the 2·WIDTH-bit product until the consumer accepts it. It sits wherever area matters more than latency, and is a drop-in replacement behind a handshake for the combinational multiplier.

## Interface
Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- sgn  input  1  1 = both operands are two's-complement; 0 = both unsigned.
- out_valid  output  1  product m is valid; high only in DONE.
- out_ready  input  1  consumer accepts m.
- m  output  2·WIDTH  product; signed or unsigned per the captured sgn.
- busy  output  1  high in RUN or DONE.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE with m=0, out_valid=0, busy=0 and in_ready=1. The internal accumulator, counter and operand registers are cleared.
- IDLE: if in_valid && in_ready at a rising edge, the block registers a, b and sgn and goes to RUN.
  - Signed capture: the magnitudes |a| and |b| are stored, plus neg = a[MSB] XOR b[MSB].
  - Unsigned capture: a and b are stored as-is, with neg=0.
- RUN: one iteration per cycle, counter 0..WIDTH-1. Each iteration:
  - if the multiplier LSB is 1, add the multiplicand shifted by the count into the 2·WIDTH-bit accumulator;
  - shift the multiplier right by 1.
  - On the iteration where counter = WIDTH-1, the block loads m with the accumulator, or with its two's-complement negation if neg=1. It then goes to DONE.
- DONE: m is held stable while out_valid=1. If out_valid && out_ready at an edge, the block goes to IDLE.
- In DONE, out_valid and m are registered outputs. in_ready and busy are decoded from state only, with no combinational path from any input.
- Width rules:
  - Magnitudes use WIDTH bits and the accumulator uses 2·WIDTH bits.
  - Unsigned max (2^W−1)² fits in 2·WIDTH bits.
  - Signed extreme (−2^(W−1))·(−2^(W−1)) = 2^(2W−2) is a positive value that fits in 2·WIDTH signed, so no overflow is possible.
  - The magnitude of −2^(W−1) is 2^(W−1), held as unsigned WIDTH bits.
- Boundary conditions:
  - in_valid during RUN or DONE is ignored; operands are not captured and in_ready=0.
  - A zero operand still takes the full WIDTH iterations, so latency is fixed.
  - Back-to-back operation: the IDLE cycle after DONE is mandatory, so the maximum throughput is one product per WIDTH+2 cycles.
  - out_ready is a don't-care outside DONE.
  - rst asserted in any state, including mid-RUN or in DONE with a pending product, returns to IDLE on that edge. The in-flight result is discarded, m=0, and no out_valid pulse occurs.
  - rst has priority over a simultaneous in handshake or out handshake.

## Timing
- Cycle 0: in_valid=1 in IDLE, captured at the end of cycle 0.
- Cycles 1..WIDTH: RUN, with in_ready=0 and busy=1.
- Cycle WIDTH+1: out_valid=1 and m is valid. This is a fixed latency of WIDTH+1 cycles from the accept edge to out_valid.
- If out_ready=1 in cycle WIDTH+1, then in_ready=1 in cycle WIDTH+2.
- Each cycle that out_ready stays low extends DONE by one cycle, with m unchanged.
- The cycle after reset deasserts, in_ready=1.

## Test plan
- WIDTH=4, sgn=0: a=15, b=15 → out_valid exactly 5 cycles after the accept cycle, m=8'hE1 (225). Then a=0, b=9 → m=0 with the same latency.
- WIDTH=4, sgn=1: a=4'h8, b=4'h8 → m=8'h40 (+64). Then a=4'hD (−3), b=4'h5 → m=8'hF1 (−15). Then a=4'h7, b=4'hF (−1) → m=8'hF9.
- Backpressure: hold out_ready=0 for 6 cycles in DONE → out_valid stays 1 and m is stable. Toggle in_valid with new operands during the wait → they are not captured. After out_ready=1, in_ready rises the next cycle.
- Reset mid-RUN: assert rst at RUN iteration 2 → next cycle IDLE, m=0, busy=0, in_ready=1, and no out_valid. A following 3×5 unsigned operation returns m=15.
- WIDTH=8: 1000 random operands over both sgn values, with random out_ready stalls → every m matches a golden model. The sum of out_valid handshakes equals the sum of input handshakes, and latency is always 9 cycles.
